// File: rtl/ntt_mdc_sequencer_if.sv
// Handshake and pipeline-control bundle for the NTT MDC sequencer.
// The master side issues commands and returns pipeline finish strobes; the slave side is the sequencer.
interface ntt_mdc_sequencer_if #(
  parameter int unsigned LOGN = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_intt;
  logic            cmd_gs;
  logic            rd_en;
  logic [LOGN-2:0] rd_addr;
  logic            pipe_start;
  logic            pipe_intt;
  logic            pipe_btf_gs;
  logic            pipe_finish;
  logic            wr_en;
  logic [LOGN-2:0] wr_addr;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output cmd_valid, cmd_intt, cmd_gs, pipe_finish,
    input  cmd_ready, rd_en, rd_addr, pipe_start, pipe_intt, pipe_btf_gs,
           wr_en, wr_addr, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_intt, cmd_gs, pipe_finish,
    output cmd_ready, rd_en, rd_addr, pipe_start, pipe_intt, pipe_btf_gs,
           wr_en, wr_addr, busy, done, err
  );
endinterface

// File: rtl/ntt_mdc_sequencer.sv
// Sequences one NTT pass through an MDC butterfly pipeline: streams P pair reads,
// collects P pipeline results as writes, and guards the drain phase with a watchdog.
module ntt_mdc_sequencer #(
  parameter int unsigned LOGN    = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic                clk,
  input logic                rst,
  ntt_mdc_sequencer_if.slave bus
);
  localparam int unsigned P   = 1 << (LOGN - 1);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t            state, state_nx;
  logic [LOGN-2:0]   rd_cnt;
  logic [LOGN-1:0]   wr_cnt;
  logic [WDW-1:0]    wd;
  logic [RD_LAT-1:0] dly;
  logic              intt_q, gs_q, done_q, err_q;
  logic              accept, complete, timeout, wr_full, wr_fire, err_set;

  // Write counting runs in LOAD as well, so early pipeline results are not lost.
  assign wr_full = (wr_cnt == LOGN'(P));
  assign wr_fire = (state != IDLE) && bus.pipe_finish && !wr_full;
  assign err_set = (bus.pipe_finish && (state == IDLE || wr_full)) || timeout;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        accept   = 1'b1;
        state_nx = LOAD;
      end
      LOAD: if (rd_cnt == '1) state_nx = DRAIN;
      DRAIN: begin
        // A run whose results all arrived during LOAD completes on the first DRAIN cycle.
        if (wr_full || (wr_fire && wr_cnt == LOGN'(P - 1))) complete = 1'b1;
        else if (!wr_fire && wd == WDW'(TIMEOUT - 1))        timeout  = 1'b1;
        if (complete || timeout) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      wd     <= '0;
      dly    <= '0;
      intt_q <= 1'b0;
      gs_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rd_cnt <= (state == LOAD) ? rd_cnt + 1'b1 : '0;
      if (accept || complete || timeout) wr_cnt <= '0;
      else if (wr_fire)                  wr_cnt <= wr_cnt + 1'b1;
      wd <= (state != DRAIN || wr_fire) ? '0 : wd + 1'b1;
      dly[0] <= (state == LOAD);
      for (int unsigned i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
      if (accept) begin
        intt_q <= bus.cmd_intt;
        gs_q   <= bus.cmd_gs;
      end
      done_q <= complete || timeout;
      if (err_set)     err_q <= 1'b1;
      else if (accept) err_q <= 1'b0;
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.rd_en       = (state == LOAD);
  assign bus.rd_addr     = rd_cnt;
  assign bus.pipe_start  = dly[RD_LAT-1];
  assign bus.pipe_intt   = intt_q;
  assign bus.pipe_btf_gs = gs_q;
  assign bus.wr_en       = wr_fire;
  assign bus.wr_addr     = wr_cnt[LOGN-2:0];
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_ntt_mdc_sequencer.sv
// Randomised bench for ntt_mdc_sequencer (LOGN=4, RD_LAT=1, TIMEOUT=16) against a
// transaction-timeline reference model computed from the finish-strobe pattern.
module tb_ntt_mdc_sequencer;
  localparam int LOGN    = 4;
  localparam int P       = 1 << (LOGN - 1);
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 16;
  localparam int MAXO    = 80;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cur_err  = 1'b0;
  bit   cur_intt = 1'b0;
  bit   cur_gs   = 1'b0;

  ntt_mdc_sequencer_if #(.LOGN(LOGN)) bus ();

  ntt_mdc_sequencer #(.LOGN(LOGN), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 late burst, 1 early burst, 2 random gaps, 3 one extra strobe, 4 no strobes, 5 all in LOAD
  task automatic run_txn(input bit chained, input bit intt, input bit gs,
                         input bit hold, input bit alt_intt, input bit alt_gs, input int mode);
    bit fin[MAXO];
    bit exp_wr[MAXO];
    int exp_wa[MAXO];
    bit errset[MAXO];
    int s, n, r, e, d;
    bit acc;
    for (int o = 0; o < MAXO; o++) begin
      fin[o] = 1'b0; exp_wr[o] = 1'b0; exp_wa[o] = 0; errset[o] = 1'b0;
    end
    case (mode)
      0: for (int k = 0; k < P; k++) fin[20+k] = 1'b1;
      1: for (int k = 0; k < P; k++) fin[5+k] = 1'b1;
      2: begin
        s = $urandom_range(1, 12);
        for (int k = 0; k < P; k++) begin
          fin[s] = 1'b1;
          s += 1 + $urandom_range(0, 3);
        end
      end
      3: begin
        s = $urandom_range(2, 12);
        for (int k = 0; k <= P; k++) fin[s+k] = 1'b1;
      end
      5: for (int k = 0; k < P; k++) fin[1+k] = 1'b1;
      default: ;
    endcase

    // Timeline: reads occupy offsets 1..P, drain begins at P+1; the first P strobes are
    // written in order, surplus strobes are errors, and a silent drain times out.
    d = P + 1; n = 0; r = d; e = -1;
    for (int o = 1; o < MAXO && e < 0; o++) begin
      if (fin[o]) begin
        if (n < P) begin exp_wr[o] = 1'b1; exp_wa[o] = n; n++; end
        else errset[o] = 1'b1;
      end
      if (o >= d) begin
        if (n == P) e = o + 1;
        else if (!exp_wr[o] && (o - r) == TIMEOUT - 1) begin e = o + 1; errset[o] = 1'b1; end
      end
      if (exp_wr[o]) r = (o + 1 > d) ? o + 1 : d;
    end
    if (e < 0) begin
      chk("model_end", 32'(e), 32'(MAXO));
      e = MAXO - 1;
    end

    acc = 1'b0;
    for (int o = chained ? 1 : 0; o <= e; o++) begin
      @(posedge clk);
      #1;
      rst             = 1'b0;
      bus.cmd_valid   = (o == 0) || hold;
      bus.cmd_intt    = (o == 0) ? intt : alt_intt;
      bus.cmd_gs      = (o == 0) ? gs : alt_gs;
      bus.pipe_finish = (o == 0) ? 1'b0 : fin[o];
      @(negedge clk);
      chk($sformatf("ready@%0d", o), bus.cmd_ready, (o == 0 || o == e));
      chk($sformatf("busy@%0d", o), bus.busy, (o >= 1 && o < e));
      chk($sformatf("rd_en@%0d", o), bus.rd_en, (o >= 1 && o <= P));
      if (o >= 1 && o <= P) chk($sformatf("rd_addr@%0d", o), bus.rd_addr, o - 1);
      chk($sformatf("pipe_start@%0d", o), bus.pipe_start, (o - RD_LAT >= 1 && o - RD_LAT <= P));
      chk($sformatf("wr_en@%0d", o), bus.wr_en, (o >= 1 && o < e) ? exp_wr[o] : 1'b0);
      if (o >= 1 && o < e && exp_wr[o]) chk($sformatf("wr_addr@%0d", o), bus.wr_addr, exp_wa[o]);
      chk($sformatf("done@%0d", o), bus.done, (o == e));
      chk($sformatf("err@%0d", o), bus.err, (o == 0) ? cur_err : acc);
      chk($sformatf("pipe_intt@%0d", o), bus.pipe_intt, (o == 0) ? cur_intt : intt);
      chk($sformatf("pipe_gs@%0d", o), bus.pipe_btf_gs, (o == 0) ? cur_gs : gs);
      if (o >= 1 && o < e) acc |= errset[o];
    end
    cur_err  = hold ? fin[e] : (acc | fin[e]);
    cur_intt = hold ? alt_intt : intt;
    cur_gs   = hold ? alt_gs : gs;
  endtask

  task automatic idle(input int n, input bit spurious);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      bus.cmd_valid   = 1'b0;
      bus.pipe_finish = spurious && (k == 0);
      @(negedge clk);
      chk("idle_ready", bus.cmd_ready, 1'b1);
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_wr_en", bus.wr_en, 1'b0);
      chk("idle_done", bus.done, 1'b0);
      chk("idle_err", bus.err, cur_err);
      if (bus.pipe_finish) cur_err = 1'b1;
    end
  endtask

  initial begin
    bit chained, intt, gs, hold, ai, ag, pi, pg;
    int mode;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_intt = 1'b0; bus.cmd_gs = 1'b0; bus.pipe_finish = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rd_en", bus.rd_en, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_pipe_start", bus.pipe_start, 1'b0);
    chk("rst_pipe_intt", bus.pipe_intt, 1'b0);
    chk("rst_pipe_gs", bus.pipe_btf_gs, 1'b0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(2, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    idle(3, 1'b1);
    run_txn(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    idle(1, 1'b0);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    idle(1, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    idle(2, 1'b0);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);

    // Abort a run at offset 4; the run_txn below accepts on the first cycle after reset.
    @(posedge clk);
    #1 bus.cmd_valid = 1'b1; bus.cmd_intt = 1'b1; bus.cmd_gs = 1'b1;
    for (int o = 1; o <= 4; o++) begin
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      if (o == 4) rst = 1'b1;
      @(negedge clk);
      chk($sformatf("abort_rd_addr@%0d", o), bus.rd_addr, o - 1);
      chk($sformatf("abort_intt@%0d", o), bus.pipe_intt, 1'b1);
    end
    cur_err = 1'b0; cur_intt = 1'b0; cur_gs = 1'b0;
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    chained = 1'b0; pi = 1'b0; pg = 1'b0;
    for (int i = 0; i < 12; i++) begin
      intt = chained ? pi : 1'($urandom_range(0, 1));
      gs   = chained ? pg : 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 5);
      hold = (mode != 3) && (i < 11) && ($urandom_range(0, 3) == 0);
      ai   = 1'($urandom_range(0, 1));
      ag   = 1'($urandom_range(0, 1));
      run_txn(chained, intt, gs, hold, ai, ag, mode);
      chained = hold; pi = ai; pg = ag;
      if (!hold) idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ntt_mdc_sequencer.md
NTT_MDC_SEQUENCER -- requirements
Module: ntt_mdc_sequencer

Interface
REQ-001 SHALL have parameter LOGN, default 8: log2 of polynomial length N; a transform moves N/2 coefficient pairs (P = 2^(LOGN-1)).
REQ-002 SHALL have parameter RD_LAT, default 1: coefficient-memory read latency in cycles, range 1..4.
REQ-003 SHALL have parameter TIMEOUT, default 4096: idle-cycle limit while draining.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  transform request.
REQ-007 cmd_ready  out  1  request accepted when high together with cmd_valid.
REQ-008 cmd_intt  in  1  1 = inverse transform, 0 = forward.
REQ-009 cmd_gs  in  1  1 = Gentleman-Sande butterfly, 0 = Cooley-Tukey.
REQ-010 rd_en  out  1  coefficient-pair read strobe.
REQ-011 rd_addr  out  LOGN-1  pair read address.
REQ-012 pipe_start  out  1  valid strobe into first stage of the pipeline.
REQ-013 pipe_intt  out  1  intt configuration to all stages.
REQ-014 pipe_btf_gs  out  1  butterfly-type configuration to all stages.
REQ-015 pipe_finish  in  1  output-valid strobe from last stage.
REQ-016 wr_en  out  1  result-pair write strobe.
REQ-017 wr_addr  out  LOGN-1  result-pair write address.
REQ-018 busy  out  1  transform in progress.
REQ-019 done  out  1  single-cycle completion pulse.
REQ-020 err  out  1  sticky error flag.

Function
REQ-021 SHALL implement states IDLE, LOAD, DRAIN; cmd_ready = 1 only in IDLE and combinationally equal to (state==IDLE).
REQ-022 Accept at cycle T (IDLE, cmd_valid=1): pipe_intt/pipe_btf_gs registered from cmd_intt/cmd_gs, visible T+1, held constant until the next accept; err cleared at T+1; state -> LOAD.
REQ-023 LOAD: rd_en = 1 for exactly P consecutive cycles T+1..T+P; rd_addr = 0,1,..,P-1 in those cycles; on the last read (rd_addr = P-1) state -> DRAIN.
REQ-024 pipe_start SHALL equal rd_en delayed by exactly RD_LAT cycles (shift register, cleared by rst), producing P contiguous strobes.
REQ-025 Write side, in LOAD or DRAIN: each cycle with pipe_finish=1 and write count < P gives wr_en=1 (same cycle, combinational), wr_addr = write count (0..P-1), then count increments; finish strobes beyond P are ignored and set err.
REQ-026 Write counting SHALL run independently of LOAD, so finish strobes arriving before reading completes are captured.
REQ-027 When the P-th write occurs in DRAIN, done = 1 the following cycle; state -> IDLE that same cycle; counters reset to 0.
REQ-028 Watchdog: in DRAIN, count cycles since last wr_en (or entry into DRAIN); reaching TIMEOUT sets err, pulses done, forces IDLE.
REQ-029 pipe_finish=1 while IDLE SHALL set err and produce no wr_en.
REQ-030 busy = 1 in LOAD and DRAIN, 0 in IDLE.
REQ-031 rd_addr/wr_addr SHALL never wrap inside one transform; width is exactly LOGN-1 bits.

Reset
REQ-032 rst SHALL force IDLE, cmd_ready=1, rd_en=0, rd_addr=0, pipe_start=0 (whole delay line), pipe_intt=0, pipe_btf_gs=0, wr_en=0, wr_addr=0, busy=0, done=0, err=0, watchdog=0.
REQ-033 rst asserted mid-transform SHALL abort with no done pulse; the next cycle after rst deasserts accepts a new command.

Verification (LOGN=4, P=8, RD_LAT=1)
REQ-034 Forward: cmd at T with intt=0, gs=0; model finish 8 cycles starting T+20 -> rd_en T+1..T+8 addr 0..7, pipe_start T+2..T+9, wr_en T+20..T+27 addr 0..7, done at T+28, err=0.
REQ-035 Early finish: finish strobes from T+5 -> writes addr 0..7 at T+5..T+12, done T+13, no lost beats.
REQ-036 Config hold: cmd intt=1, gs=1 then cmd_valid held with intt=0 during run -> pipe_intt/pipe_btf_gs stay 1 until done, second command accepted only after return to IDLE.
REQ-037 Timeout (TIMEOUT=16): finish never asserted -> err=1 and done at 16 cycles after DRAIN entry, busy=0 next cycle.
REQ-038 Spurious/extra finish: finish in IDLE, or 9 strobes in a run -> err=1, only 8 wr_en; rst at T+4 mid-run -> all outputs reset, no done.
